// File: rtl/seq_gen_010_101_pkg.sv
// Shared definitions for the 010/101 sequence generator: FSM encoding,
// detector window constants and the window-match helper.
package seq_gen_010_101_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [2:0] WIN_010 = 3'b010;
  localparam logic [2:0] WIN_101 = 3'b101;

  function automatic logic win_match(input logic [2:0] win);
    return (win == WIN_010) || (win == WIN_101);
  endfunction

endpackage

// File: rtl/seq_gen_010_101_hits.sv
// Overlapping 010/101 window matcher with saturating hit counter; doubles as
// the golden reference model for the Mealy and Moore detectors.
module seq_hit_counter
  import seq_gen_010_101_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          shift_i,
  input  logic          bit_i,
  output logic [CW-1:0] hits_o
);

  localparam logic [CW-1:0] HITS_MAX = {CW{1'b1}};

  logic [1:0]    hist_q, hist_d;
  logic [1:0]    nbits_q, nbits_d;
  logic [CW-1:0] hits_q, hits_d;

  // A load restarts the history with its own first bit, so it never scores.
  always_comb begin
    hist_d  = hist_q;
    nbits_d = nbits_q;
    hits_d  = hits_q;
    if (load_i) begin
      hist_d  = {1'b0, bit_i};
      nbits_d = 2'd1;
      hits_d  = '0;
    end else if (shift_i) begin
      hist_d  = {hist_q[0], bit_i};
      nbits_d = (nbits_q == 2'd2) ? 2'd2 : nbits_q + 2'd1;
      if ((nbits_q == 2'd2) && win_match({hist_q, bit_i}) && (hits_q != HITS_MAX)) begin
        hits_d = hits_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q  <= 2'b00;
      nbits_q <= 2'd0;
      hits_q  <= '0;
    end else begin
      hist_q  <= hist_d;
      nbits_q <= nbits_d;
      hits_q  <= hits_d;
    end
  end

  assign hits_o = hits_q;

endmodule

// File: rtl/seq_gen_010_101.sv
// Serial pattern generator feeding the 010/101 detectors: FSM plus shift
// datapath, with window counting delegated to seq_hit_counter.
module seq_gen_010_101
  import seq_gen_010_101_pkg::*;
#(
  parameter int PW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [PW-1:0] pattern,
  input  logic [2:0]    len,
  input  logic          rpt,
  output logic          x,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] hits
);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [PW-1:0] sh_q, sh_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    len_q, len_d;
  logic          rpt_q, rpt_d;
  logic          stop_q, stop_d;
  logic          x_q, x_d;
  logic          load_s, shift_s;

  // sh_q holds the bits still to be sent, MSB next; a stop seen anywhere in
  // SHIFT is remembered so it ends the run at the next pattern boundary.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    stop_d  = stop_q;
    x_d     = x_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d = 1'b1;
        if (start) begin
          pat_d   = pattern;
          sh_d    = pattern << 1;
          len_d   = len;
          rpt_d   = rpt;
          stop_d  = 1'b0;
          idx_d   = 3'd0;
          x_d     = pattern[PW-1];
          load_s  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        stop_d = stop_q | stop;
        if (idx_q == len_q) begin
          if (rpt_q && !(stop_q || stop)) begin
            idx_d   = 3'd0;
            x_d     = pat_q[PW-1];
            sh_d    = pat_q << 1;
            shift_s = 1'b1;
          end else begin
            x_d     = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          idx_d   = idx_q + 3'd1;
          x_d     = sh_q[PW-1];
          sh_d    = sh_q << 1;
          shift_s = 1'b1;
        end
      end
      ST_DONE: begin
        x_d     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        x_d     = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      rpt_q   <= 1'b0;
      stop_q  <= 1'b0;
      x_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
      stop_q  <= stop_d;
      x_q     <= x_d;
    end
  end

  seq_hit_counter #(.CW(CW)) u_hits (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load_s),
    .shift_i (shift_s),
    .bit_i   (x_d),
    .hits_o  (hits)
  );

  assign x    = x_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule
